// File: rtl/jg3_vote_collector_pkg.sv
// jg3_pkg: shared types and constants for the three-judge vote collector.
//   state_t    : collector FSM states (IDLE / COLLECT / PRESENT)
//   JUDGE_A/B/C: bit positions of each judge inside a vote vector
//   vote_vec_t : one bit per judge, {A,B,C}
// Optional feature macro used by the users of this package: JG3_VERDICT_EN.
package jg3_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PRESENT = 2'd2
  } state_t;

  localparam int JUDGE_A = 2;  // chief judge
  localparam int JUDGE_B = 1;
  localparam int JUDGE_C = 0;

  typedef logic [2:0] vote_vec_t;

  localparam vote_vec_t ALL_VOTED = 3'b111;

endpackage

// File: rtl/jg3_vote_collector_if.sv
// jg3_vote_collector_if: groups the judge inputs and the result handshake of
// the vote collector.
//   start, vote_stb, vote_val : judge side requests / votes
//   abc, abc_valid, abc_ready : result vector and its valid/ready handshake
//   missing, timeout, busy    : result qualifiers and activity status
//   pass_x, reject_y          : verdicts, present only with JG3_VERDICT_EN
// Modports: master = the collector, slave = judges plus downstream logic.
interface jg3_vote_collector_if;
  import jg3_pkg::*;

  logic      start;
  vote_vec_t vote_stb;
  vote_vec_t vote_val;
  vote_vec_t abc;
  logic      abc_valid;
  logic      abc_ready;
  vote_vec_t missing;
  logic      timeout;
  logic      busy;
`ifdef JG3_VERDICT_EN
  logic      pass_x;
  logic      reject_y;
`endif

  modport master (
    input  start, vote_stb, vote_val, abc_ready,
    output abc, abc_valid, missing, timeout, busy
`ifdef JG3_VERDICT_EN
    , output pass_x, reject_y
`endif
  );

  modport slave (
    output start, vote_stb, vote_val, abc_ready,
    input  abc, abc_valid, missing, timeout, busy
`ifdef JG3_VERDICT_EN
    , input pass_x, reject_y
`endif
  );

endinterface

// File: rtl/jg3_vote_collector_verdict.sv
// jg3_verdict: purely combinational verdict decode of a collected vote vector.
//   i_abc      : {A,B,C} votes, 1 = approve
//   o_pass_x   : chief approves and at least one other judge approves
//   o_reject_y : nobody approves
// Instantiated by jg3_vote_collector only when JG3_VERDICT_EN is defined.
module jg3_verdict
  import jg3_pkg::*;
(
  input  vote_vec_t i_abc,
  output logic      o_pass_x,
  output logic      o_reject_y
);

  assign o_pass_x   = i_abc[JUDGE_A] & (i_abc[JUDGE_B] | i_abc[JUDGE_C]);
  assign o_reject_y = ~(i_abc[JUDGE_A] | i_abc[JUDGE_B] | i_abc[JUDGE_C]);

endmodule

// File: rtl/jg3_vote_collector.sv
// jg3_vote_collector: opens a voting window on start, collects one vote per
// judge (A = chief, B, C), closes on the third vote or after WINDOW_CYCLES
// collect cycles, then offers the {A,B,C} vector downstream via valid/ready.
// Judges that never voted read as reject and are flagged in missing.
//   clk  : rising-edge clock
//   rst_n: synchronous active-low reset
//   bus  : jg3_vote_collector_if.master (start, vote_stb, vote_val,
//          abc, abc_valid, abc_ready, missing, timeout, busy
//          [, pass_x, reject_y])
// Parameter WINDOW_CYCLES (1..65535) sets the window length.
// Macro JG3_VERDICT_EN adds registered pass_x / reject_y outputs.
// All outputs come straight from registers.
module jg3_vote_collector
  import jg3_pkg::*;
#(
  parameter int WINDOW_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  jg3_vote_collector_if.master   bus
);

  localparam int              CNT_W    = $clog2(WINDOW_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW_CYCLES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  vote_vec_t        r_voted;
  vote_vec_t        r_abc;
  vote_vec_t        r_missing;
  logic             r_valid;
  logic             r_timeout;
  logic             r_busy;

  vote_vec_t        w_take;
  vote_vec_t        w_voted_nxt;
  vote_vec_t        w_abc_nxt;
  logic             w_all;
  logic             w_expire;

  // Only the first strobe of each judge counts; later ones are masked off.
  assign w_take      = bus.vote_stb & ~r_voted;
  assign w_voted_nxt = r_voted | w_take;
  assign w_abc_nxt   = (r_abc & ~w_take) | (bus.vote_val & w_take);
  // Completion includes votes landing this cycle, so a vote on the expiry
  // cycle that fills the mask closes the window as complete, not timed out.
  assign w_all       = (w_voted_nxt == ALL_VOTED);
  assign w_expire    = (r_cnt == LAST_CNT);

`ifdef JG3_VERDICT_EN
  logic w_pass_x;
  logic w_reject_y;
  logic r_pass_x;
  logic r_reject_y;

  // Decoded from the vector being closed so the verdict lands with abc.
  jg3_verdict u_verdict (
    .i_abc      (w_abc_nxt),
    .o_pass_x   (w_pass_x),
    .o_reject_y (w_reject_y)
  );
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_voted   <= '0;
      r_abc     <= '0;
      r_missing <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_busy    <= 1'b0;
`ifdef JG3_VERDICT_EN
      r_pass_x   <= 1'b0;
      r_reject_y <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state   <= COLLECT;
            r_cnt     <= '0;
            r_voted   <= '0;
            r_abc     <= '0;
            r_missing <= '0;
            r_timeout <= 1'b0;
            r_busy    <= 1'b1;
          end
        end

        COLLECT: begin
          r_abc   <= w_abc_nxt;
          r_voted <= w_voted_nxt;
          if (w_all || w_expire) begin
            r_state   <= PRESENT;
            r_valid   <= 1'b1;
            r_timeout <= ~w_all;
            r_missing <= ~w_voted_nxt;
`ifdef JG3_VERDICT_EN
            r_pass_x   <= w_pass_x;
            r_reject_y <= w_reject_y;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        PRESENT: begin
          if (bus.abc_ready) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.abc       = r_abc;
  assign bus.abc_valid = r_valid;
  assign bus.missing   = r_missing;
  assign bus.timeout   = r_timeout;
  assign bus.busy      = r_busy;
`ifdef JG3_VERDICT_EN
  assign bus.pass_x    = r_pass_x;
  assign bus.reject_y  = r_reject_y;
`endif

endmodule

// File: tb/tb_jg3_vote_collector.sv
// tb_jg3_vote_collector: scoreboard bench for jg3_vote_collector with
// WINDOW_CYCLES = 8. A driver issues vote schedules (directed and random);
// a reference model derived from the voting rules pushes the expected result;
// a monitor pops and compares whenever abc_valid is presented.
// Honours JG3_VERDICT_EN for the pass_x / reject_y checks.
module tb_jg3_vote_collector;
  import jg3_pkg::*;

  localparam int W  = 8;
  localparam int NS = W + 4;  // schedule slots, runs past the window

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jg3_vote_collector_if bus();

  jg3_vote_collector #(.WINDOW_CYCLES(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    vote_vec_t abc;
    vote_vec_t missing;
    logic      timeout;
    int        close;
    int        exp_cyc;
  } exp_t;

  exp_t      q[$];
  int        n_chk = 0;
  int        n_pass = 0;
  int        cyc = 0;
  int        rdy_mode = 0;  // 0 random, 1 hold low, 2 hold high
  vote_vec_t stb_s[NS];
  vote_vec_t val_s[NS];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Reference: each judge's vote is its first strobe; the window closes at
  // the latest first-vote if all three land inside it, else at the last slot.
  function automatic exp_t model(input int t_start);
    exp_t e;
    int   f[3];
    bit   all;
    for (int i = 0; i < 3; i++) begin
      f[i] = -1;
      for (int c = NS - 1; c >= 0; c--) if (stb_s[c][i]) f[i] = c;
    end
    all = 1'b1;
    e.close = 0;
    for (int i = 0; i < 3; i++) begin
      if (f[i] < 0 || f[i] > W - 1) all = 1'b0;
      else if (f[i] > e.close) e.close = f[i];
    end
    if (!all) e.close = W - 1;
    e.abc = '0;
    e.missing = '0;
    for (int i = 0; i < 3; i++) begin
      if (f[i] >= 0 && f[i] <= e.close) e.abc[i] = val_s[f[i]][i];
      else e.missing[i] = 1'b1;
    end
    e.timeout = !all;
    e.exp_cyc = t_start + 1 + e.close;
    return e;
  endfunction

  task automatic clr_sched();
    for (int c = 0; c < NS; c++) begin
      stb_s[c] = '0;
      val_s[c] = 3'($urandom);  // unstrobed value bits are noise
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("return_idle", bus.busy, 1'b0);
  endtask

  task automatic run_txn(input bit rnd_start, input bit bp);
    exp_t e;
    int   t_start;
    @(posedge clk); #1;
    bus.start = 1'b1;
    t_start = cyc + 1;
    e = model(t_start);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1'b1);
    q.push_back(e);
    for (int c = 0; c < NS; c++) begin
      bus.vote_stb = stb_s[c];
      bus.vote_val = val_s[c];
      bus.start    = rnd_start && (c <= e.close) && ($urandom % 4 == 0);
      @(posedge clk); #1;
    end
    bus.vote_stb = '0;
    bus.start    = 1'b0;
    if (bp) begin
      for (int k = 0; k < 5; k++) begin
        bus.start = ~bus.start;
        @(posedge clk); #1;
      end
      bus.start = 1'b0;
      chk("bp_valid_held", bus.abc_valid, 1'b1);
      rdy_mode = 2;
    end
    wait_idle();
    if (bp) begin
      repeat (3) @(posedge clk);
      #1;
      chk("bp_start_dropped", bus.busy, 1'b0);
      chk("bp_no_valid", bus.abc_valid, 1'b0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_abc"}, bus.abc, 3'b000);
    chk({tag, "_valid"}, bus.abc_valid, 1'b0);
    chk({tag, "_missing"}, bus.missing, 3'b000);
    chk({tag, "_timeout"}, bus.timeout, 1'b0);
    chk({tag, "_busy"}, bus.busy, 1'b0);
`ifdef JG3_VERDICT_EN
    chk({tag, "_pass_x"}, bus.pass_x, 1'b0);
    chk({tag, "_reject_y"}, bus.reject_y, 1'b0);
`endif
  endtask

  // Ready generator
  initial begin
    bus.abc_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.abc_ready = ($urandom % 3) != 0;
        1:       bus.abc_ready = 1'b0;
        default: bus.abc_ready = 1'b1;
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    exp_t cur;
    bit   have;
    have = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have = 1'b0;
      end else if (bus.abc_valid) begin
        if (!have) begin
          if (q.size() == 0) begin
            chk("unexpected_valid", bus.abc_valid, 1'b0);
          end else begin
            cur  = q.pop_front();
            have = 1'b1;
            chk("abc", bus.abc, cur.abc);
            chk("timeout", bus.timeout, cur.timeout);
            chk("missing", bus.missing, cur.missing);
            chk("valid_cycle", cyc, cur.exp_cyc);
`ifdef JG3_VERDICT_EN
            chk("pass_x", bus.pass_x, cur.abc[2] & (cur.abc[1] | cur.abc[0]));
            chk("reject_y", bus.reject_y, cur.abc == 3'b000);
`endif
          end
        end else begin
          chk("abc_hold", bus.abc, cur.abc);
          chk("missing_hold", bus.missing, cur.missing);
          chk("timeout_hold", bus.timeout, cur.timeout);
        end
        if (have) chk("busy_in_present", bus.busy, 1'b1);
        if (bus.abc_ready) have = 1'b0;
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start    = 1'b0;
    bus.vote_stb = '0;
    bus.vote_val = '0;
    rst_n        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Complete vote set on separate cycles: A=1, B=0, C=1
    clr_sched();
    stb_s[0] = 3'b100; val_s[0][2] = 1'b1;
    stb_s[1] = 3'b010; val_s[1][1] = 1'b0;
    stb_s[2] = 3'b001; val_s[2][0] = 1'b1;
    run_txn(1'b0, 1'b0);

    // Timeout, only B votes approve
    clr_sched();
    stb_s[3] = 3'b010; val_s[3][1] = 1'b1;
    run_txn(1'b0, 1'b0);

    // Simultaneous votes all reject, then A re-strobes approve
    clr_sched();
    stb_s[0] = 3'b111; val_s[0] = 3'b000;
    stb_s[1] = 3'b100; val_s[1] = 3'b111;
    run_txn(1'b0, 1'b0);

    // C votes on the expiry cycle
    clr_sched();
    stb_s[0]     = 3'b100; val_s[0][2]     = 1'b1;
    stb_s[2]     = 3'b010; val_s[2][1]     = 1'b1;
    stb_s[W - 1] = 3'b001; val_s[W - 1][0] = 1'b0;
    run_txn(1'b0, 1'b0);

    // Backpressure with start pulses while presenting
    clr_sched();
    stb_s[1] = 3'b011; val_s[1] = 3'b010;
    stb_s[2] = 3'b100; val_s[2] = 3'b100;
    rdy_mode = 1;
    run_txn(1'b0, 1'b1);
    rdy_mode = 0;

    // Reset mid-collect after one vote
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.vote_stb = 3'b100;
    bus.vote_val = 3'b111;
    @(posedge clk); #1;
    bus.vote_stb = '0;
    rst_n        = 1'b0;
    @(posedge clk); #1;
    chk_reset_outputs("midreset");
    rst_n = 1'b1;
    clr_sched();
    stb_s[4] = 3'b001; val_s[4][0] = 1'b1;
    run_txn(1'b0, 1'b0);

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      clr_sched();
      for (int i = 0; i < 3; i++) begin
        if ($urandom % 6 != 0) begin
          int f;
          int nrep;
          f = $urandom_range(0, W + 1);
          stb_s[f][i] = 1'b1;
          nrep = $urandom % 3;
          for (int r = 0; r < nrep; r++) stb_s[$urandom_range(f, NS - 1)][i] = 1'b1;
        end
      end
      run_txn(1'b1, 1'b0);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
